z80_bus_tracer: RTL and testbench
=================================

Name: z80_bus_tracer

Overview:
- Passive bus monitor downstream of the tv80s CPU bus. It sits on the same wires as the testbench memory/IO model.
- Decodes each completed Z80 bus cycle into one trace record: type, address, data and timestamp.
- Buffers records in a FIFO and drains them over a valid/ready interface.
- Lets CPU instruction tests check the exact bus sequence, e.g. fetch, displacement read, read-modify-write.

Parameters:
- DEPTH, 16: FIFO depth in records; power of two, minimum 2.
- TS_W, 16: timestamp counter width in bits.
- LVL_W, 5: width of `level`; equals log2(DEPTH)+1.

Ports:
- clk  in  1  CPU clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: empties the FIFO, zeroes the timestamp, clears overflow and drop_count.
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU bus controls, active low.
- A  in  16  CPU address bus.
- di  in  8  data driven to the CPU (read data).
- dout  in  8  data driven by the CPU (write data).
- trace_valid  out  1  FIFO head record is available.
- trace_ready  in  1  consumer accepts the head record.
- trace_type  out  3  0=opcode fetch, 1=mem read, 2=mem write, 3=io read, 4=io write, 5=int ack.
- trace_addr  out  16  captured address.
- trace_data  out  8  captured data; 00 for int ack.
- trace_time  out  TS_W  timestamp at the first active cycle of the bus cycle.
- level  out  LVL_W  current FIFO occupancy.
- overflow  out  1  sticky: a record was lost because the FIFO was full.
- drop_count  out  8  number of lost records; saturates at FF.

Behaviour:
- Reset values: all outputs 0, the FIFO is empty and the timestamp is 0. `clear` has the same effect synchronously, and takes priority over push and pop in that cycle.
- Timestamp counter increments every clock and wraps modulo 2^TS_W.
- Combinational `active` term:
  - Memory part: mreq_n=0, rfsh_n=1, and (rd_n=0 or wr_n=0).
  - IO part: iorq_n=0, and (rd_n=0 or wr_n=0 or m1_n=0).
- Refresh cycles (mreq_n=0 with rfsh_n=0) never produce a record.
- Two-state FSM:
  - IDLE -> CAPT when `active`=1. In that cycle, latch the timestamp, A, and the type decoded from m1_n/mreq_n/iorq_n/wr_n.
  - CAPT: every cycle, resample A and type; resample data from di for reads, dout for writes. The last sample before release is what gets recorded.
  - CAPT -> IDLE when `active`=0. In that edge, push the record.
- Record visibility: `trace_valid` and the head fields appear the cycle after the push edge (one-cycle latency).
- Fast re-entry: if `active` is 0 on one edge and 1 on the next, a new CAPT starts. A zero-gap cycle therefore needs one inactive sample, and gets one record per strobe.
- Pop: occurs when trace_valid=1 and trace_ready=1. Head fields stay stable while trace_valid=1 and trace_ready=0.
- Push and pop in the same edge:
  - FIFO full: both succeed, so no overflow occurs.
  - FIFO empty: the pushed record becomes valid next cycle.
- Push while full without a pop: the record is discarded, overflow is set to 1, and drop_count is incremented (saturating). FIFO contents are unchanged.
- Pointers use one extra wrap bit, so full (level=DEPTH) and empty are unambiguous.
- Asynchronous reset mid-CAPT: the partial record is discarded and the FSM returns to IDLE.

Optional Feature:
- TRACE_FILTER_EN.
- Defined:
  - Adds input ports `filt_lo` (16 bits) and `filt_hi` (16 bits).
  - Pushes only records with filt_lo <= trace_addr <= filt_hi.
  - Filtered-out records are not overflow and do not increment drop_count.
  - filt_lo > filt_hi filters out every record.
- Not defined: the filter ports are absent and every cycle is recorded.

Test Plan:
1. Reset, then drive an M1 fetch at A=0000 with di=DD for 2 cycles, with trace_ready=1 -> one record: type 0, addr 0000, data DD, time equals the counter at the first active edge; level returns to 0.
2. Mem write A=A4A1, dout=44, then IO read A=00FE, di=5A, with trace_ready=0 -> level=2. Records in order: (2, A4A1, 44), then (3, 00FE, 5A).
3. Refresh cycle (mreq_n=0, rfsh_n=0, rd_n=1) and an int-ack cycle (m1_n=0, iorq_n=0) -> refresh produces no record; int ack produces (5, A, 00).
4. With trace_ready=0, run DEPTH+3 mem reads -> level=DEPTH, overflow=1, drop_count=03. The first DEPTH records are intact; a later pulse of `clear` zeroes everything.
5. FIFO full, then drive a completing cycle coincident with trace_ready=1 -> no overflow, level stays at DEPTH, and the new record is last.
6. With TRACE_FILTER_EN, filt_lo=A000 and filt_hi=AFFF: reads at 0002 and A4A1 -> only the A4A1 record is pushed; drop_count stays 00.

Source files
------------

// File: rtl/z80_bus_tracer.sv
// ---------------------------------------------------------------------------
// z80_bus_tracer
//   Passive monitor on the tv80s CPU bus. Each completed bus cycle is decoded
//   into one trace record {type, addr, data, time}. Records are queued in a
//   FIFO and drained over a valid/ready port.
//
//   Record types: 0 opcode fetch, 1 mem read, 2 mem write, 3 io read,
//                 4 io write, 5 interrupt acknowledge (data forced to 00).
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   clear               synchronous flush of FIFO, timestamp, overflow, drops
//   m1_n .. rfsh_n      CPU bus controls (active low)
//   A, di, dout         address, read data (to CPU), write data (from CPU)
//   trace_*             head record and its valid/ready handshake
//   level               FIFO occupancy (0..DEPTH)
//   overflow            sticky: a record was lost to a full FIFO
//   drop_count          number of lost records, saturating at FF
//
// Optional feature (macro TRACE_FILTER_EN)
//   Adds filt_lo/filt_hi; only records with filt_lo <= addr <= filt_hi are
//   pushed. Filtered records are not counted as drops.
// ---------------------------------------------------------------------------
module z80_bus_tracer #(
   parameter int DEPTH = 16,
   parameter int TS_W  = 16,
   parameter int LVL_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
`ifdef TRACE_FILTER_EN
   input  logic [15:0]      filt_lo,
   input  logic [15:0]      filt_hi,
`endif
   input  logic             m1_n,
   input  logic             mreq_n,
   input  logic             iorq_n,
   input  logic             rd_n,
   input  logic             wr_n,
   input  logic             rfsh_n,
   input  logic [15:0]      A,
   input  logic [7:0]       di,
   input  logic [7:0]       dout,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [2:0]       trace_type,
   output logic [15:0]      trace_addr,
   output logic [7:0]       trace_data,
   output logic [TS_W-1:0]  trace_time,
   output logic [LVL_W-1:0] level,
   output logic             overflow,
   output logic [7:0]       drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = 3 + 16 + 8 + TS_W;

   typedef enum logic {S_IDLE, S_CAPT} state_t;

   state_t          r_state, w_next;
   logic            w_active, w_capture, w_start, w_push;
   logic [2:0]      w_type;
   logic [7:0]      w_data;
   logic            w_pass;

   logic [TS_W-1:0] r_ts;
   logic [2:0]      r_type;
   logic [15:0]     r_addr;
   logic [7:0]      r_data;
   logic [TS_W-1:0] r_time;

   logic [RW-1:0]   r_mem [DEPTH];
   logic [AW:0]     r_wr, r_rd;
   logic            w_full, w_empty, w_pop, w_wr_en, w_drop;
   logic [RW-1:0]   w_head;
   logic            r_ovf;
   logic [7:0]      r_drop;

   // Refresh (mreq with rfsh low) is excluded from the memory term; the m1
   // leg of the IO term catches interrupt acknowledge.
   assign w_active = (!mreq_n && rfsh_n && (!rd_n || !wr_n)) ||
                     (!iorq_n && (!rd_n || !wr_n || !m1_n));

   always_comb begin
      w_type = 3'd3;
      if (!mreq_n) begin
         if (!m1_n)      w_type = 3'd0;
         else if (!wr_n) w_type = 3'd2;
         else            w_type = 3'd1;
      end else if (!m1_n) begin
         w_type = 3'd5;
      end else if (!wr_n) begin
         w_type = 3'd4;
      end
   end

   always_comb begin
      w_data = di;
      if (w_type == 3'd5)                        w_data = 8'h00;
      else if (w_type == 3'd2 || w_type == 3'd4) w_data = dout;
   end

   // ---------------- capture FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_start   = 1'b0;
      w_push    = 1'b0;
      case (r_state)
         S_IDLE: if (w_active) begin
            w_next    = S_CAPT;
            w_capture = 1'b1;
            w_start   = 1'b1;
         end
         S_CAPT: if (w_active) begin
            w_capture = 1'b1;
         end else begin
            w_next = S_IDLE;
            w_push = 1'b1;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Fields are resampled every active cycle, so the record holds the last
   // active sample; the timestamp is only taken on entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_type <= '0;
         r_addr <= '0;
         r_data <= '0;
         r_time <= '0;
      end else if (w_capture) begin
         r_type <= w_type;
         r_addr <= A;
         r_data <= w_data;
         if (w_start) r_time <= r_ts;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   r_ts <= '0;
      else if (clear) r_ts <= '0;
      else            r_ts <= r_ts + TS_W'(1);
   end

`ifdef TRACE_FILTER_EN
   assign w_pass = (r_addr >= filt_lo) && (r_addr <= filt_hi);
`else
   assign w_pass = 1'b1;
`endif

   // ---------------- FIFO ----------------
   assign w_empty = (r_wr == r_rd);
   assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop   = !w_empty && trace_ready;
   // A pop in the same edge frees the slot, so a full FIFO still accepts.
   assign w_wr_en = w_push && w_pass && (!w_full || w_pop);
   assign w_drop  = w_push && w_pass && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_wr_en && !clear) r_mem[r_wr[AW-1:0]] <= {r_type, r_addr, r_data, r_time};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr   <= '0;
         r_rd   <= '0;
         r_ovf  <= 1'b0;
         r_drop <= '0;
      end else if (clear) begin
         r_wr   <= '0;
         r_rd   <= '0;
         r_ovf  <= 1'b0;
         r_drop <= '0;
      end else begin
         if (w_wr_en) r_wr <= r_wr + 1'b1;
         if (w_pop)   r_rd <= r_rd + 1'b1;
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
         end
      end
   end

   // Head fields read as zero while empty so outputs are 0 out of reset.
   assign w_head      = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
   assign trace_valid = !w_empty;
   assign trace_type  = w_head[RW-1 -: 3];
   assign trace_addr  = w_head[RW-4 -: 16];
   assign trace_data  = w_head[TS_W+7 -: 8];
   assign trace_time  = w_head[TS_W-1:0];
   assign level       = LVL_W'(r_wr - r_rd);
   assign overflow    = r_ovf;
   assign drop_count  = r_drop;

endmodule

// File: tb/tb_z80_bus_tracer.sv
module tb_z80_bus_tracer;
   localparam int DEPTH = 16;
   localparam int TS_W  = 16;
   localparam int LVL_W = 5;

   typedef struct {
      logic [2:0]  t;
      logic [15:0] a;
      logic [7:0]  d;
      logic [15:0] ts;
   } rec_t;

   logic clk, reset_n, clear;
   logic m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
   logic [15:0] A;
   logic [7:0]  di, dout;
   logic trace_valid, trace_ready;
   logic [2:0]  trace_type;
   logic [15:0] trace_addr;
   logic [7:0]  trace_data;
   logic [TS_W-1:0]  trace_time;
   logic [LVL_W-1:0] level;
   logic overflow;
   logic [7:0] drop_count;
`ifdef TRACE_FILTER_EN
   logic [15:0] filt_lo, filt_hi;
`endif

   z80_bus_tracer #(.DEPTH(DEPTH), .TS_W(TS_W), .LVL_W(LVL_W)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear),
`ifdef TRACE_FILTER_EN
      .filt_lo(filt_lo), .filt_hi(filt_hi),
`endif
      .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n),
      .wr_n(wr_n), .rfsh_n(rfsh_n), .A(A), .di(di), .dout(dout),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_type(trace_type), .trace_addr(trace_addr),
      .trace_data(trace_data), .trace_time(trace_time),
      .level(level), .overflow(overflow), .drop_count(drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   rec_t        mq[$];
   logic [15:0] m_ts;
   logic        m_ovf;
   logic [7:0]  m_drop;
   bit          m_push;
   rec_t        m_rec;
   bit          rnd_rdy;

   int n_chk, n_fail;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock; the model applies the rules to the inputs seen at the edge.
   task automatic tick();
      bit pop, pass;
      if (rnd_rdy) trace_ready = 1'($urandom);
      @(posedge clk);
      pop  = trace_ready && (mq.size() > 0);
      pass = 1'b1;
`ifdef TRACE_FILTER_EN
      pass = (m_rec.a >= filt_lo) && (m_rec.a <= filt_hi);
`endif
      if (clear) begin
         mq.delete(); m_ts = '0; m_ovf = 1'b0; m_drop = '0;
      end else begin
         m_ts = m_ts + 16'd1;
         if (pop) void'(mq.pop_front());
         if (m_push && pass) begin
            if (mq.size() < DEPTH) mq.push_back(m_rec);
            else begin
               m_ovf = 1'b1;
               if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_bus();
      m1_n = 1; mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; rfsh_n = 1;
      A = 16'($urandom); di = 8'($urandom); dout = 8'($urandom);
   endtask

   task automatic set_bus(input int ty, input logic [15:0] a, input logic [7:0] v);
      idle_bus();
      A = a;
      case (ty)
         0: begin m1_n = 0; mreq_n = 0; rd_n = 0; di = v; end
         1: begin mreq_n = 0; rd_n = 0; di = v; end
         2: begin mreq_n = 0; wr_n = 0; dout = v; end
         3: begin iorq_n = 0; rd_n = 0; di = v; end
         4: begin iorq_n = 0; wr_n = 0; dout = v; end
         default: begin m1_n = 0; iorq_n = 0; di = v; end
      endcase
   endtask

   // Active for ncyc edges (data varies, last value counts), then one idle edge.
   task automatic bus_cyc(input int ty, input logic [15:0] a, input logic [7:0] d,
                          input int ncyc, input bit pop_at_push);
      rec_t r;
      r.t = 3'(ty); r.a = a; r.d = (ty == 5) ? 8'h00 : d; r.ts = m_ts;
      for (int i = 0; i < ncyc; i++) begin
         set_bus(ty, a, (i == ncyc - 1) ? d : 8'($urandom));
         tick();
      end
      idle_bus();
      m_rec = r; m_push = 1;
      if (pop_at_push) trace_ready = 1;
      tick();
      m_push = 0;
      if (pop_at_push) trace_ready = 0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".lvl"},  32'(level),       32'(mq.size()));
      chk({tag, ".vld"},  32'(trace_valid), 32'(mq.size() > 0));
      chk({tag, ".ovf"},  32'(overflow),    32'(m_ovf));
      chk({tag, ".drop"}, 32'(drop_count),  32'(m_drop));
      if (mq.size() > 0) begin
         chk({tag, ".type"}, 32'(trace_type), 32'(mq[0].t));
         chk({tag, ".addr"}, 32'(trace_addr), 32'(mq[0].a));
         chk({tag, ".data"}, 32'(trace_data), 32'(mq[0].d));
         chk({tag, ".time"}, 32'(trace_time), 32'(mq[0].ts));
      end
   endtask

   task automatic drain(input string tag);
      rnd_rdy = 0;
      trace_ready = 1;
      for (int i = 0; i < 4 * DEPTH && mq.size() > 0; i++) begin
         check_state(tag);
         tick();
      end
      trace_ready = 0;
      chk({tag, ".empty"}, 32'(level), 32'd0);
   endtask

   task automatic pulse_clear();
      clear = 1; tick(); clear = 0;
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      mq.delete(); m_ts = '0; m_ovf = 0; m_drop = '0; m_push = 0; rnd_rdy = 0;
      m_rec = '{t: 3'd0, a: 16'd0, d: 8'd0, ts: 16'd0};
      reset_n = 0; clear = 0; trace_ready = 0;
`ifdef TRACE_FILTER_EN
      filt_lo = 16'h0000; filt_hi = 16'hFFFF;
`endif
      idle_bus();
      repeat (2) @(negedge clk);
      chk("rst.vld",  32'(trace_valid), 0);
      chk("rst.type", 32'(trace_type),  0);
      chk("rst.addr", 32'(trace_addr),  0);
      chk("rst.data", 32'(trace_data),  0);
      chk("rst.time", 32'(trace_time),  0);
      chk("rst.lvl",  32'(level),       0);
      chk("rst.ovf",  32'(overflow),    0);
      chk("rst.drop", 32'(drop_count),  0);
      reset_n = 1;

      // 1: fetch, consumer ready
      tick();
      trace_ready = 1;
      bus_cyc(0, 16'h0000, 8'hDD, 2, 0);
      check_state("t1");
      chk("t1.time_abs", 32'(trace_time), 32'd1);
      tick();
      check_state("t1b");
      trace_ready = 0;

      // 2: mem write then io read held in FIFO
      bus_cyc(2, 16'hA4A1, 8'h44, 1, 0);
      bus_cyc(3, 16'h00FE, 8'h5A, 2, 0);
      chk("t2.lvl2", 32'(level), 32'd2);
      drain("t2");

      // 3: refresh gives nothing, int ack gives data 00
      idle_bus(); mreq_n = 0; rfsh_n = 0;
      tick(); tick();
      idle_bus(); tick();
      chk("t3.rfsh", 32'(level), 32'd0);
      bus_cyc(5, 16'h1238, 8'hFF, 2, 0);
      chk("t3.iack_data", 32'(trace_data), 32'h00);
      drain("t3");

      // randomized traffic with a randomly stalling consumer
      rnd_rdy = 1;
      for (int i = 0; i < 60; i++) begin
         bus_cyc($urandom_range(0, 5), 16'($urandom), 8'($urandom), $urandom_range(1, 3), 0);
         check_state("rnd");
         for (int k = $urandom_range(0, 2); k > 0; k--) begin
            idle_bus(); tick();
         end
      end
      drain("rnd_d");
      pulse_clear();
      check_state("clr0");

      // 4: overflow by DEPTH+3 reads
      for (int i = 0; i < DEPTH + 3; i++)
         bus_cyc(1, 16'(16'h4000 + i), 8'(i), 1, 0);
      chk("t4.lvl",  32'(level),      32'(DEPTH));
      chk("t4.ovf",  32'(overflow),   32'd1);
      chk("t4.drop", 32'(drop_count), 32'd3);
      check_state("t4");

      // 5: full FIFO, completion coincident with a pop
      bus_cyc(2, 16'hBEEF, 8'h77, 1, 1);
      chk("t5.lvl",  32'(level),      32'(DEPTH));
      chk("t5.drop", 32'(drop_count), 32'd3);
      check_state("t5");
      drain("t5d");

      // drop counter saturation, then clear
      for (int i = 0; i < DEPTH + 260; i++)
         bus_cyc(1, 16'($urandom), 8'($urandom), 1, 0);
      chk("sat.drop", 32'(drop_count), 32'hFF);
      check_state("sat");
      pulse_clear();
      chk("clr.lvl",  32'(level),      32'd0);
      chk("clr.ovf",  32'(overflow),   32'd0);
      chk("clr.drop", 32'(drop_count), 32'd0);
      chk("clr.vld",  32'(trace_valid), 32'd0);
      bus_cyc(4, 16'h0042, 8'h99, 1, 0);
      check_state("post_clr");
      drain("post_clr_d");

`ifdef TRACE_FILTER_EN
      // 6: address window filter
      filt_lo = 16'hA000; filt_hi = 16'hAFFF;
      bus_cyc(1, 16'h0002, 8'h11, 1, 0);
      bus_cyc(1, 16'hA4A1, 8'h22, 1, 0);
      chk("t6.lvl",  32'(level),      32'd1);
      chk("t6.addr", 32'(trace_addr), 32'hA4A1);
      chk("t6.drop", 32'(drop_count), 32'd0);
      check_state("t6");
      drain("t6d");
      filt_lo = 16'h0001; filt_hi = 16'h0000;
      bus_cyc(1, 16'h0000, 8'h33, 1, 0);
      chk("t6.empty_win", 32'(level), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
